// File: rtl/mult_div_sequencer.sv
// Iterative multiply/divide unit for the multicycle MIPS datapath.
// Owns HI/LO and runs a 32-step shift-add multiply or restoring divide.
module mult_div_sequencer #(
    parameter int DATA_WIDTH       = 32,
    parameter int ALUControl_width = 5,
    parameter int CNT_width        = 5
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        Start,
    input  logic [ALUControl_width-1:0] ALUControl,
    input  logic [DATA_WIDTH-1:0]       SrcA,
    input  logic [DATA_WIDTH-1:0]       SrcB,
    input  logic                        MTHI,
    input  logic                        MTLO,
    output logic [DATA_WIDTH-1:0]       HI,
    output logic [DATA_WIDTH-1:0]       LO,
    output logic                        Busy,
    output logic                        Done,
    output logic                        DivZero
);

    localparam int W = DATA_WIDTH;

    localparam logic [ALUControl_width-1:0] OP_MULT  = ALUControl_width'(9);
    localparam logic [ALUControl_width-1:0] OP_DIV   = ALUControl_width'(10);
    localparam logic [ALUControl_width-1:0] OP_MULTU = ALUControl_width'(12);
    localparam logic [ALUControl_width-1:0] OP_DIVU  = ALUControl_width'(13);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t               state;
    logic [W-1:0]         opb;
    logic [2*W-1:0]       acc;
    logic [CNT_width-1:0] cnt;
    logic                 neg_lo;
    logic                 neg_hi;
    logic                 is_div;

    logic                 is_mul_op;
    logic                 is_div_op;
    logic                 sgn_op;
    logic [W-1:0]         abs_a;
    logic [W-1:0]         abs_b;
    logic [W:0]           mul_sum;
    logic [2*W-1:0]       mul_next;
    logic [W:0]           r_sh;
    logic [W-1:0]         r_sub;
    logic [2*W-1:0]       div_next;
    logic [2*W-1:0]       prod;
    logic [W-1:0]         fix_hi;
    logic [W-1:0]         fix_lo;

    always_comb begin
        is_mul_op = (ALUControl == OP_MULT) || (ALUControl == OP_MULTU);
        is_div_op = (ALUControl == OP_DIV)  || (ALUControl == OP_DIVU);
        sgn_op    = (ALUControl == OP_MULT) || (ALUControl == OP_DIV);
        abs_a     = (sgn_op && SrcA[W-1]) ? -SrcA : SrcA;
        abs_b     = (sgn_op && SrcB[W-1]) ? -SrcB : SrcB;

        // Multiplier lives in acc's low half and is shifted out as the product shifts in.
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : {(W+1){1'b0}});
        mul_next  = {mul_sum, acc[W-1:1]};

        r_sh      = acc[2*W-1:W-1];
        r_sub     = r_sh[W-1:0] - opb;
        if (r_sh >= {1'b0, opb})
            div_next = {r_sub, acc[W-2:0], 1'b1};
        else
            div_next = {r_sh[W-1:0], acc[W-2:0], 1'b0};

        prod = neg_lo ? -acc : acc;
        if (is_div) begin
            fix_hi = neg_hi ? -acc[2*W-1:W] : acc[2*W-1:W];
            fix_lo = neg_lo ? -acc[W-1:0]   : acc[W-1:0];
        end else begin
            fix_hi = prod[2*W-1:W];
            fix_lo = prod[W-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            HI      <= '0;
            LO      <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
            opb     <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
            is_div  <= 1'b0;
        end else begin
            Done    <= 1'b0;
            DivZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (MTHI) HI <= SrcA;
                    if (MTLO) LO <= SrcA;
                    if (Start && (is_mul_op || is_div_op)) begin
                        opb    <= is_mul_op ? abs_a : abs_b;
                        acc    <= {{W{1'b0}}, (is_mul_op ? abs_b : abs_a)};
                        cnt    <= '0;
                        is_div <= is_div_op;
                        neg_lo <= sgn_op & (SrcA[W-1] ^ SrcB[W-1]);
                        neg_hi <= is_mul_op ? (sgn_op & (SrcA[W-1] ^ SrcB[W-1]))
                                            : (sgn_op & SrcA[W-1]);
                        Busy   <= 1'b1;
                        if (is_div_op && (SrcB == '0)) begin
                            state   <= DONE;
                            Done    <= 1'b1;
                            DivZero <= 1'b1;
                        end else begin
                            state <= is_mul_op ? MUL : DIV;
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) state <= FIX;
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) state <= FIX;
                end
                FIX: begin
                    HI    <= fix_hi;
                    LO    <= fix_lo;
                    Done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer: hand-computed results, timing,
// HI/LO moves, ignored requests and asynchronous reset.
module tb_mult_div_sequencer;

    logic        CLK;
    logic        RST;
    logic        Start;
    logic [4:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        MTHI;
    logic        MTLO;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        Done;
    logic        DivZero;

    int ncmp = 0;
    int nerr = 0;

    mult_div_sequencer #(
        .DATA_WIDTH       (32),
        .ALUControl_width (5),
        .CNT_width        (5)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Start      (Start),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .MTHI       (MTHI),
        .MTLO       (MTLO),
        .HI         (HI),
        .LO         (LO),
        .Busy       (Busy),
        .Done       (Done),
        .DivZero    (DivZero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the sampling edge.
    task automatic start_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; ALUControl = code; SrcA = a; SrcB = b;
        @(negedge CLK);
        Start = 1'b0;
    endtask

    // n0 = edges elapsed since the sampling edge at the current negedge.
    task automatic finish_op(input string tag, input int n0, input logic [31:0] eh, input logic [31:0] el);
        int n = n0;
        while (Done !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd33);
        chk({tag, "_busy_at_done"}, {31'd0, Busy}, 32'd1);
        chk({tag, "_hi"}, HI, eh);
        chk({tag, "_lo"}, LO, el);
        @(negedge CLK);
        chk({tag, "_done_fall"}, {31'd0, Done}, 32'd0);
        chk({tag, "_busy_fall"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        RST = 1'b0; Start = 1'b0; ALUControl = '0; SrcA = '0; SrcB = '0;
        MTHI = 1'b0; MTLO = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_divzero", {31'd0, DivZero}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        start_op(5'd9, 32'hFFFF_FFFF, 32'h0000_0002);
        chk("mult_busy_rise", {31'd0, Busy}, 32'd1);
        finish_op("mult_neg", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        start_op(5'd12, 32'hFFFF_FFFF, 32'h0000_0002);
        finish_op("multu", 0, 32'h0000_0001, 32'hFFFF_FFFE);

        start_op(5'd10, 32'hFFFF_FFF9, 32'h0000_0002);
        finish_op("div_neg", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        start_op(5'd13, 32'd7, 32'd2);
        finish_op("divu", 0, 32'h0000_0001, 32'h0000_0003);

        start_op(5'd13, 32'd5, 32'd0);
        chk("dz_done", {31'd0, Done}, 32'd1);
        chk("dz_flag", {31'd0, DivZero}, 32'd1);
        chk("dz_busy", {31'd0, Busy}, 32'd1);
        chk("dz_hi_kept", HI, 32'h0000_0001);
        chk("dz_lo_kept", LO, 32'h0000_0003);
        @(negedge CLK);
        chk("dz_done_fall", {31'd0, Done}, 32'd0);
        chk("dz_flag_fall", {31'd0, DivZero}, 32'd0);
        chk("dz_busy_fall", {31'd0, Busy}, 32'd0);

        start_op(5'd10, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_ovf", 0, 32'h0000_0000, 32'h8000_0000);

        MTHI = 1'b1; SrcA = 32'h1234_5678;
        @(negedge CLK);
        MTHI = 1'b0;
        chk("mthi", HI, 32'h1234_5678);
        MTLO = 1'b1; SrcA = 32'h9ABC_DEF0;
        @(negedge CLK);
        MTLO = 1'b0;
        chk("mtlo", LO, 32'h9ABC_DEF0);
        chk("mtlo_hi_kept", HI, 32'h1234_5678);
        MTHI = 1'b1; MTLO = 1'b1; SrcA = 32'hA5A5_5A5A;
        @(negedge CLK);
        MTHI = 1'b0; MTLO = 1'b0;
        chk("mt_both_hi", HI, 32'hA5A5_5A5A);
        chk("mt_both_lo", LO, 32'hA5A5_5A5A);

        start_op(5'd9, 32'd6, 32'd7);
        repeat (4) @(negedge CLK);
        MTHI = 1'b1; MTLO = 1'b1; SrcA = 32'h1234_5678;
        @(negedge CLK);
        MTHI = 1'b0; MTLO = 1'b0;
        chk("mt_busy_hi_kept", HI, 32'hA5A5_5A5A);
        finish_op("mt_busy_mult", 5, 32'h0000_0000, 32'd42);

        start_op(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(negedge CLK);
        Start = 1'b1; ALUControl = 5'd13; SrcA = 32'd100; SrcB = 32'd3;
        @(negedge CLK);
        Start = 1'b0;
        finish_op("restart_ignored", 11, 32'hFFFF_FFFE, 32'h0000_0001);

        start_op(5'd0, 32'd1, 32'd2);
        chk("add_busy", {31'd0, Busy}, 32'd0);
        @(negedge CLK);
        chk("add_busy_later", {31'd0, Busy}, 32'd0);
        chk("add_done", {31'd0, Done}, 32'd0);

        start_op(5'd12, 32'hFFFF_FFFF, 32'h0000_0002);
        repeat (17) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("arst_busy", {31'd0, Busy}, 32'd0);
        chk("arst_done", {31'd0, Done}, 32'd0);
        chk("arst_hi", HI, 32'd0);
        chk("arst_lo", LO, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        start_op(5'd9, 32'd3, 32'd5);
        finish_op("post_rst_mult", 0, 32'd0, 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/mult_div_sequencer.md
# mult_div_sequencer

Iterative multiply/divide sequencer for the multicycle MIPS datapath. It executes the ALUControl codes the single-cycle ALU does not finish: mult (9), div (10), multu (12) and divu (13). It owns the HI/LO register pair and runs a 32-iteration shift-add or restoring-divide loop. It raises Busy so the main control FSM stalls mfhi/mflo and further mult/div until Done.

## Interface

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width
- ALUControl_width, 5, width of the ALUControl code from the ALU decoder
- CNT_width, 5, iteration counter width (log2 DATA_WIDTH)

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous, active-low reset
- Start  input  1  one-cycle request to begin an operation
- ALUControl  input  ALUControl_width  operation code; only 9, 10, 12 and 13 start an operation
- SrcA  input  DATA_WIDTH  rs operand (multiplicand/dividend); also mthi/mtlo data
- SrcB  input  DATA_WIDTH  rt operand (multiplier/divisor)
- MTHI  input  1  write SrcA to HI (IDLE only)
- MTLO  input  1  write SrcA to LO (IDLE only)
- HI  output  DATA_WIDTH  HI register (product high half or remainder)
- LO  output  DATA_WIDTH  LO register (product low half or quotient)
- Busy  output  1  high whenever state is not IDLE
- Done  output  1  one-cycle pulse on completion
- DivZero  output  1  one-cycle pulse, coincident with Done, when div/divu had SrcB == 0

## Operation

- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - Start with code 9/12 latches |SrcA|, |SrcB| (raw for 12), clears the 64-bit accumulator and counter, and goes to MUL.
  - Start with code 10/13 latches the operands the same way (raw for 13) and goes to DIV. If SrcB == 0, it goes straight to DONE instead, with DivZero set.
  - Start with any other code is ignored.
- Sign capture:
  - mult: the result is negated if SrcA[31] ^ SrcB[31].
  - div: the quotient is negated if the signs differ; the remainder takes the sign of SrcA.
  - Unsigned codes never negate.
- MUL, each cycle: if multiplier LSB = 1, add the multiplicand to the accumulator high half. Then shift {carry, acc} right by 1 and shift the multiplier right by 1. Counter increments. Go to FIX after count 31.
- DIV, each cycle (restoring): shift {rem, quot} left by 1; trial = rem - divisor. If trial is non-negative, rem = trial and quot[0] = 1. Go to FIX after count 31.
- FIX: apply the captured negations (two's complement, 32-bit wrap), write HI/LO, go to DONE.
- DONE: Done = 1 for this cycle only; return to IDLE next cycle.
- Div by zero: HI/LO are left unchanged.
- -2^31 / -1 (div): LO = 0x80000000 and HI = 0 (wraparound, no trap).
- MTHI/MTLO:
  - Honoured only in IDLE, taking effect at the next edge.
  - Both may be asserted together.
  - If Start is accepted in the same cycle, MTHI/MTLO still write, then the operation overwrites HI/LO at FIX.
  - Ignored while Busy.
- Start while Busy is ignored (no queueing).
- Reset (asynchronous, any state): state = IDLE; HI = LO = 0; Busy = Done = DivZero = 0; counter and internal registers = 0. An in-flight operation is discarded.

## Timing

- Edge 0 samples Start in IDLE. Edges 1–32 perform the 32 iterations. Edge 33 (FIX) updates HI/LO and enters DONE. Edge 34 returns to IDLE.
- Busy is high from the cycle after edge 0 through the DONE cycle: 34 cycles.
- Done is high for the single cycle after edge 33. HI/LO are already valid in that cycle.
- A new Start is accepted in the IDLE cycle after DONE, so back-to-back operations issue every 35 cycles.
- Div by zero: edge 0 goes to DONE; Done and DivZero are high in cycle 1; Busy is high for 1 cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- mult 0xFFFFFFFF × 0x00000002 -> after 34 Busy cycles: HI = 0xFFFFFFFF, LO = 0xFFFFFFFE, Done pulse of 1 cycle. The same operands with multu -> HI = 0x00000001, LO = 0xFFFFFFFE.
- div 0xFFFFFFF9 (-7) / 0x00000002 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. divu 7 / 2 -> LO = 0x00000003, HI = 0x00000001.
- Edge cases:
  - div 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
  - divu 5 / 0 -> Done and DivZero high in cycle 1; HI/LO unchanged from their preceding values.
- MTHI 0x12345678 and MTLO 0x9ABCDEF0 in IDLE -> HI/LO read back those values the next cycle. The same writes attempted mid-mult -> ignored, and the mult result appears at Done.
- Start re-asserted with a new operand at iteration 10 -> ignored; the original result is produced at the original Done cycle. Start with ALUControl = 0 (add) -> Busy stays 0.
- RST low at iteration 17 of a mult -> Busy, Done, HI and LO are 0 immediately (asynchronously). After release, a fresh mult 3 × 5 -> LO = 15, HI = 0.
